// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst read/write front end for the coprocessor's operand
// storage. Wraps an inferred synchronous single-port RAM and accepts one
// command per start strobe. Completion is signalled by a one-cycle done.
//
// Build option: define MEMBURST_BOUNDS_CHECK_EN to reject bursts that would
// run past the top address. A rejected burst completes with done and err both
// high and does not touch the RAM. Without the macro there is no err port and
// such bursts wrap back to address 0.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      command strobe, sampled only while idle
//   wr         1 = write burst, 0 = read burst
//   address    start address of the burst
//   len        burst length minus one
//   data_in    write beat data
//   in_valid   data_in valid
//   in_ready   write beat accepted this cycle when in_valid is high
//   data_out   read beat data, holds its value between beats
//   out_valid  data_out valid (no backpressure)
//   busy       command in progress, including the done cycle
//   done       one-cycle completion pulse
//   err        (MEMBURST_BOUNDS_CHECK_EN only) out-of-range command rejected
//
// States:
//   state   | meaning
//   IDLE    | waiting for start
//   WRITE   | in_ready high, one beat written per in_valid cycle
//   READ    | one address issued per cycle, read pipeline filling/streaming
//   DRAIN   | final read beat on data_out
//   DONE    | done pulse, busy still high

module mem_burst_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wr,
    input  logic [ADDR_W-1:0] address,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              done
`ifdef MEMBURST_BOUNDS_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  cnt;
    logic              issue_done;
    logic              ram_v;
    logic              ram_last;
    logic [DATA_W-1:0] ram_q;
    logic              mem_we;
    logic              mem_re;

    logic [DATA_W-1:0] mem [DEPTH];

    // Reset must suppress a beat presented on the same edge.
    assign mem_we = (state == S_WRITE) && in_valid && !reset;
    assign mem_re = (state == S_READ) && !issue_done && !reset;

    // RAM contents survive reset, so this block has none.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr] <= data_in;
        end
        if (mem_re) begin
            ram_q <= mem[ptr];
        end
    end

`ifdef MEMBURST_BOUNDS_CHECK_EN
    // One extra bit so address + len cannot overflow in the comparison.
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    logic [SUM_W-1:0] end_addr;
    logic             cmd_oob;

    assign end_addr = SUM_W'(address) + SUM_W'(len);
    assign cmd_oob  = end_addr > SUM_W'(DEPTH - 1);
`endif

    // Read path is two register stages: the RAM output register (ram_q,
    // tagged by ram_v/ram_last), then data_out. READ is left only once the
    // last beat sits in ram_q, so that beat appears on data_out during DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            issue_done <= 1'b0;
            ram_v      <= 1'b0;
            ram_last   <= 1'b0;
            in_ready   <= 1'b0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef MEMBURST_BOUNDS_CHECK_EN
            err        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr  <= address;
                        cnt  <= len;
                        busy <= 1'b1;
`ifdef MEMBURST_BOUNDS_CHECK_EN
                        if (cmd_oob) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else
`endif
                        if (wr) begin
                            state    <= S_WRITE;
                            in_ready <= 1'b1;
                        end else begin
                            state      <= S_READ;
                            issue_done <= 1'b0;
                            ram_v      <= 1'b0;
                            ram_last   <= 1'b0;
                        end
                    end
                end

                S_WRITE: begin
                    if (in_valid) begin
                        ptr <= ptr + 1'b1;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end

                S_READ: begin
                    out_valid <= ram_v;
                    if (ram_v) begin
                        data_out <= ram_q;
                    end
                    if (!issue_done) begin
                        ptr      <= ptr + 1'b1;
                        cnt      <= cnt - 1'b1;
                        ram_v    <= 1'b1;
                        ram_last <= (cnt == '0);
                        if (cnt == '0) begin
                            issue_done <= 1'b1;
                        end
                    end else begin
                        ram_v <= 1'b0;
                    end
                    if (ram_v && ram_last) begin
                        state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    out_valid <= 1'b0;
                    done      <= 1'b1;
                    state     <= S_DONE;
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
`ifdef MEMBURST_BOUNDS_CHECK_EN
                    err   <= 1'b0;
`endif
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
module tb_mem_burst_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        wr;
    logic [7:0]  address;
    logic [3:0]  len;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_out;
    logic        out_valid;
    logic        busy;
    logic        done;
`ifdef MEMBURST_BOUNDS_CHECK_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference memory image, updated from the bench's own view of accepted beats.
    logic [15:0] ref_mem [256];

    mem_burst_ctrl dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .wr(wr),
        .address(address),
        .len(len),
        .data_in(data_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_out(data_out),
        .out_valid(out_valid),
        .busy(busy),
        .done(done)
`ifdef MEMBURST_BOUNDS_CHECK_EN
        ,
        .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a write burst; beats accepted on every WRITE cycle with in_valid.
    task automatic do_write(input logic [7:0] a, input logic [3:0] l, input logic [15:0] d[$],
                            input logic [31:0] gap_mask, input int gap_pct,
                            output int ir_bad, output int last_acc, output int done_c,
                            output int ndone, output int busy_end);
        int k;
        int n;
        logic [7:0] wa;
        k = 0; n = int'(l) + 1;
        ir_bad = 0; last_acc = -1; done_c = -1; ndone = 0; busy_end = 1;
        address = a; len = l; wr = 1'b1; start = 1'b1; in_valid = 1'b0;
        tick;
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c == done_c + 1) busy_end = int'(busy);
            if (done_c >= 0 && c >= done_c + 2) break;
            if (in_ready !== (k < n)) ir_bad++;
            if (k < n) begin
                in_valid = !((c < 32) ? gap_mask[c] : 1'b0) && ($urandom_range(99) >= gap_pct);
                data_in  = d[k];
            end else begin
                in_valid = 1'b0;
            end
            tick;
            if (in_valid && k < n) begin
                wa = a + 8'(k);
                ref_mem[wa] = d[k];
                last_acc = c;
                k++;
            end
        end
        in_valid = 1'b0;
    endtask

    // Issue a read burst; c counts edges after the start edge (start edge = 0).
    task automatic do_read(input logic [7:0] a, input logic [3:0] l, input int inj,
                           output logic [15:0] beats[$], output int first_v, output int last_v,
                           output int nvalid, output int done_c, output int ndone,
                           output int ov_in_done, output int busy_end, output int err_seen);
        beats = {};
        first_v = -1; last_v = -1; nvalid = 0; done_c = -1; ndone = 0;
        ov_in_done = 0; busy_end = 1; err_seen = 0;
        address = a; len = l; wr = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (out_valid) begin
                beats.push_back(data_out);
                if (first_v < 0) first_v = c;
                last_v = c;
                nvalid++;
                if (done) ov_in_done++;
            end
            if (done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
`ifdef MEMBURST_BOUNDS_CHECK_EN
            if (err) err_seen++;
`endif
            if (done_c >= 0 && c == done_c + 1) busy_end = int'(busy);
            if (done_c >= 0 && c >= done_c + 2) break;
            if (c == inj) begin
                start = 1'b1; wr = 1'b1; address = 8'h50; len = 4'd0;
                data_in = 16'hDEAD; in_valid = 1'b1;
            end
            tick;
            if (c == inj) begin
                start = 1'b0; wr = 1'b0; in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b exp 0", done); end
        n_checks++; if (data_out !== 16'h0) begin n_errors++; $display("FAIL reset_data_out: got %h exp 0", data_out); end
`ifdef MEMBURST_BOUNDS_CHECK_EN
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b exp 0", err); end
`endif
        reset = 1'b0;
        tick;
    endtask

    task automatic test_single;
        logic [15:0] wq[$];
        logic [15:0] beats[$];
        int ir_bad, last_acc, done_c, ndone, busy_end, fv, lv, nv, ovd, ee;
        wq = {16'hBEEF};
        do_write(8'h10, 4'd0, wq, 32'h0, 0, ir_bad, last_acc, done_c, ndone, busy_end);
        n_checks++; if (ir_bad !== 0) begin n_errors++; $display("FAIL single_wr_in_ready: bad_cycles=%0d exp 0", ir_bad); end
        n_checks++; if (last_acc !== 0) begin n_errors++; $display("FAIL single_wr_accept: got cycle %0d exp 0", last_acc); end
        n_checks++; if (done_c !== 1) begin n_errors++; $display("FAIL single_wr_done: got cycle %0d exp 1", done_c); end
        n_checks++; if (ndone !== 1 || busy_end !== 0) begin n_errors++; $display("FAIL single_wr_end: ndone=%0d busy=%0d exp 1/0", ndone, busy_end); end
        do_read(8'h10, 4'd0, -1, beats, fv, lv, nv, done_c, ndone, ovd, busy_end, ee);
        n_checks++; if (fv !== 2 || nv !== 1) begin n_errors++; $display("FAIL single_rd_timing: first=%0d n=%0d exp 2/1", fv, nv); end
        n_checks++; if (beats[0] !== 16'hBEEF) begin n_errors++; $display("FAIL single_rd_data: got %h exp beef", beats[0]); end
        n_checks++; if (done_c !== 3 || ndone !== 1 || ovd !== 0 || busy_end !== 0) begin
            n_errors++; $display("FAIL single_rd_done: done_c=%0d n=%0d ov=%0d busy=%0d exp 3/1/0/0", done_c, ndone, ovd, busy_end); end
    endtask

    task automatic test_stall_burst;
        logic [15:0] wq[$];
        logic [15:0] beats[$];
        int ir_bad, last_acc, done_c, ndone, busy_end, fv, lv, nv, ovd, ee;
        wq = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        do_write(8'h20, 4'd3, wq, 32'h0000_000A, 0, ir_bad, last_acc, done_c, ndone, busy_end);
        n_checks++; if (ir_bad !== 0) begin n_errors++; $display("FAIL stall_in_ready: bad_cycles=%0d exp 0", ir_bad); end
        n_checks++; if (last_acc !== 5) begin n_errors++; $display("FAIL stall_last_accept: got %0d exp 5", last_acc); end
        n_checks++; if (done_c !== 6 || ndone !== 1 || busy_end !== 0) begin
            n_errors++; $display("FAIL stall_done: done_c=%0d n=%0d busy=%0d exp 6/1/0", done_c, ndone, busy_end); end
        do_read(8'h20, 4'd3, -1, beats, fv, lv, nv, done_c, ndone, ovd, busy_end, ee);
        n_checks++; if (fv !== 2 || lv !== 5 || nv !== 4) begin n_errors++; $display("FAIL stall_rd_timing: first=%0d last=%0d n=%0d exp 2/5/4", fv, lv, nv); end
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (beats[j] !== wq[j]) begin n_errors++; $display("FAIL stall_rd_data[%0d]: got %h exp %h", j, beats[j], wq[j]); end
        end
        n_checks++; if (done_c !== 6 || ndone !== 1 || ovd !== 0) begin n_errors++; $display("FAIL stall_rd_done: done_c=%0d n=%0d ov=%0d exp 6/1/0", done_c, ndone, ovd); end
    endtask

    task automatic test_wrap;
        logic [15:0] wq[$];
        logic [15:0] beats[$];
        int ir_bad, last_acc, done_c, ndone, busy_end, fv, lv, nv, ovd, ee;
        wq = {16'hAAA1, 16'hBBB2, 16'hCCC3};
        do_write(8'hFF, 4'd2, wq, 32'h0, 0, ir_bad, last_acc, done_c, ndone, busy_end);
        n_checks++; if (done_c !== 3 || ndone !== 1) begin n_errors++; $display("FAIL wrap_wr_done: done_c=%0d n=%0d exp 3/1", done_c, ndone); end
        do_read(8'h00, 4'd1, -1, beats, fv, lv, nv, done_c, ndone, ovd, busy_end, ee);
        n_checks++; if (beats[0] !== 16'hBBB2 || beats[1] !== 16'hCCC3) begin
            n_errors++; $display("FAIL wrap_low_words: got %h %h exp bbb2 ccc3", beats[0], beats[1]); end
        do_read(8'hFF, 4'd2, -1, beats, fv, lv, nv, done_c, ndone, ovd, busy_end, ee);
        n_checks++; if (nv !== 3 || fv !== 2) begin n_errors++; $display("FAIL wrap_rd_timing: first=%0d n=%0d exp 2/3", fv, nv); end
        for (int j = 0; j < 3; j++) begin
            n_checks++; if (beats[j] !== wq[j]) begin n_errors++; $display("FAIL wrap_rd_data[%0d]: got %h exp %h", j, beats[j], wq[j]); end
        end
    endtask

    task automatic test_start_ignored;
        logic [15:0] wq[$];
        logic [15:0] beats[$];
        int ir_bad, last_acc, done_c, ndone, busy_end, fv, lv, nv, ovd, ee;
        wq = {16'h5A5A};
        do_write(8'h50, 4'd0, wq, 32'h0, 0, ir_bad, last_acc, done_c, ndone, busy_end);
        wq = {16'(($urandom)), 16'(($urandom)), 16'(($urandom)), 16'(($urandom))};
        do_write(8'h30, 4'd3, wq, 32'h0, 0, ir_bad, last_acc, done_c, ndone, busy_end);
        do_read(8'h30, 4'd3, 1, beats, fv, lv, nv, done_c, ndone, ovd, busy_end, ee);
        n_checks++; if (nv !== 4 || fv !== 2 || lv !== 5) begin n_errors++; $display("FAIL ign_rd_timing: first=%0d last=%0d n=%0d exp 2/5/4", fv, lv, nv); end
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (beats[j] !== ref_mem[8'h30 + 8'(j)]) begin
                n_errors++; $display("FAIL ign_rd_data[%0d]: got %h exp %h", j, beats[j], ref_mem[8'h30 + 8'(j)]); end
        end
        n_checks++; if (ndone !== 1 || done_c !== 6 || busy_end !== 0) begin
            n_errors++; $display("FAIL ign_single_done: n=%0d done_c=%0d busy=%0d exp 1/6/0", ndone, done_c, busy_end); end
        do_read(8'h50, 4'd0, -1, beats, fv, lv, nv, done_c, ndone, ovd, busy_end, ee);
        n_checks++; if (beats[0] !== 16'h5A5A) begin n_errors++; $display("FAIL ign_mem50: got %h exp 5a5a", beats[0]); end
    endtask

    task automatic test_reset_mid_burst;
        logic [15:0] wq[$];
        logic [15:0] beats[$];
        int ir_bad, last_acc, done_c, ndone, busy_end, fv, lv, nv, ovd, ee;
        int done_seen;
        wq = {16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};
        do_write(8'h60, 4'd3, wq, 32'h0, 0, ir_bad, last_acc, done_c, ndone, busy_end);
        address = 8'h60; len = 4'd3; wr = 1'b1; start = 1'b1;
        tick;
        start = 1'b0; in_valid = 1'b1; data_in = 16'h1234;
        tick;
        ref_mem[8'h60] = 16'h1234;
        data_in = 16'h5678;
        tick;
        ref_mem[8'h61] = 16'h5678;
        reset = 1'b1; data_in = 16'h9999;
        tick;
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_ctrl: ir=%b busy=%b done=%b ov=%b exp 0000", in_ready, busy, done, out_valid); end
        n_checks++; if (data_out !== 16'h0) begin n_errors++; $display("FAIL rstmid_data_out: got %h exp 0", data_out); end
        reset = 1'b0; in_valid = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (done || busy) done_seen++;
            tick;
        end
        n_checks++; if (done_seen !== 0) begin n_errors++; $display("FAIL rstmid_no_done: active_cycles=%0d exp 0", done_seen); end
        reset = 1'b1; start = 1'b1; wr = 1'b0;
        tick;
        reset = 1'b0; start = 1'b0;
        tick;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_with_start: busy=%b ov=%b exp 0/0", busy, out_valid); end
        do_read(8'h60, 4'd3, -1, beats, fv, lv, nv, done_c, ndone, ovd, busy_end, ee);
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (beats[j] !== ref_mem[8'h60 + 8'(j)]) begin
                n_errors++; $display("FAIL rstmid_persist[%0d]: got %h exp %h", j, beats[j], ref_mem[8'h60 + 8'(j)]); end
        end
    endtask

    task automatic test_random;
        logic [15:0] wq[$];
        logic [15:0] beats[$];
        logic [7:0] a;
        logic [3:0] l;
        int ir_bad, last_acc, done_c, ndone, busy_end, fv, lv, nv, ovd, ee;
        for (int it = 0; it < 8; it++) begin
            l = 4'($urandom_range(15));
`ifdef MEMBURST_BOUNDS_CHECK_EN
            a = 8'($urandom_range(255 - int'(l)));
`else
            a = 8'($urandom_range(255));
`endif
            wq = {};
            for (int j = 0; j <= int'(l); j++) wq.push_back(16'($urandom));
            do_write(a, l, wq, 32'h0, 30, ir_bad, last_acc, done_c, ndone, busy_end);
            n_checks++; if (ir_bad !== 0 || done_c !== last_acc + 1 || ndone !== 1 || busy_end !== 0) begin
                n_errors++; $display("FAIL rnd_wr[%0d]: irbad=%0d done_c=%0d last=%0d n=%0d busy=%0d", it, ir_bad, done_c, last_acc, ndone, busy_end); end
            do_read(a, l, -1, beats, fv, lv, nv, done_c, ndone, ovd, busy_end, ee);
            n_checks++; if (fv !== 2 || nv !== int'(l) + 1 || lv !== int'(l) + 2 || done_c !== int'(l) + 3 || ndone !== 1 || ovd !== 0) begin
                n_errors++; $display("FAIL rnd_rd_timing[%0d]: first=%0d last=%0d n=%0d done_c=%0d len=%0d", it, fv, lv, nv, done_c, l); end
            for (int j = 0; j <= int'(l); j++) begin
                n_checks++; if (beats[j] !== ref_mem[a + 8'(j)]) begin
                    n_errors++; $display("FAIL rnd_rd_data[%0d][%0d]: got %h exp %h", it, j, beats[j], ref_mem[a + 8'(j)]); end
            end
        end
    endtask

`ifdef MEMBURST_BOUNDS_CHECK_EN
    task automatic test_bounds;
        logic [15:0] wq[$];
        logic [15:0] beats[$];
        int ir_bad, last_acc, done_c, ndone, busy_end, fv, lv, nv, ovd, ee;
        wq = {16'hC0C0, 16'hC1C1, 16'hC2C2, 16'hC3C3};
        do_write(8'hFC, 4'd3, wq, 32'h0, 0, ir_bad, last_acc, done_c, ndone, busy_end);
        address = 8'hFE; len = 4'd3; wr = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        n_checks++; if (done !== 1'b1 || err !== 1'b1) begin n_errors++; $display("FAIL oob_rd_flags: done=%b err=%b exp 1/1", done, err); end
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_errors++; $display("FAIL oob_rd_ctrl: ov=%b ir=%b busy=%b exp 0/0/1", out_valid, in_ready, busy); end
        tick;
        n_checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL oob_rd_exit: done=%b err=%b busy=%b ov=%b exp 0000", done, err, busy, out_valid); end
        address = 8'hFD; len = 4'd3; wr = 1'b1; start = 1'b1; in_valid = 1'b1; data_in = 16'hEEEE;
        tick;
        start = 1'b0;
        n_checks++; if (done !== 1'b1 || err !== 1'b1 || in_ready !== 1'b0) begin
            n_errors++; $display("FAIL oob_wr_flags: done=%b err=%b ir=%b exp 1/1/0", done, err, in_ready); end
        tick;
        in_valid = 1'b0;
        do_read(8'hFC, 4'd3, -1, beats, fv, lv, nv, done_c, ndone, ovd, busy_end, ee);
        n_checks++; if (ee !== 0 || nv !== 4 || done_c !== 6) begin n_errors++; $display("FAIL inrange_rd: err_cycles=%0d n=%0d done_c=%0d exp 0/4/6", ee, nv, done_c); end
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (beats[j] !== wq[j]) begin n_errors++; $display("FAIL inrange_data[%0d]: got %h exp %h", j, beats[j], wq[j]); end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; wr = 1'b0; address = '0; len = '0;
        data_in = '0; in_valid = 1'b0;
        test_reset;
        test_single;
        test_stall_burst;
`ifndef MEMBURST_BOUNDS_CHECK_EN
        test_wrap;
`endif
        test_start_ignored;
        test_reset_mid_burst;
        test_random;
`ifdef MEMBURST_BOUNDS_CHECK_EN
        test_bounds;
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
